lg_drv: RTL and testbench
=========================

// Module: lg_drv
// PURPOSE
// - Pin-driver stage directly downstream of the logic generator; consumes its AXI4-stream of {o,e} samples.
// - Drives GPIO value/enable with break-before-make dead time on newly driven bits.
// - Holds or parks the pins on stream underrun and counts underruns for software.
// PARAMETERS
// - DW   8   pin count; width of the o and e fields
// - CWD  8   dead-time counter width (cycles)
// - CWU  16  underrun counter width (saturating)
// PORTS
// - clk       in   1        clock; the stream ACLK (stream ARESETn unused)
// - rstn      in   1        reset, asynchronous, active-low
// - sti       s    axi4_stream_if, DN=1, DT=lg_pkg::lg_t   input {o,e} samples
// - cfg_ena   in   1        0: discard input, release all pins
// - cfg_hld   in   1        underrun: 1 hold last sample, 0 park (gpio_e=0)
// - cfg_dtm   in   CWD      dead time in cycles; 0 disables
// - sts_clr   in   1        pulse: clear sts_udr
// - gpio_o    out  DW       pin output value
// - gpio_e    out  DW       pin output enable, 1 = driven
// - sts_act   out  1        state != IDLE
// - sts_udr   out  CWU      underrun cycles, saturating
// BEHAVIOUR
// - Reset (async): gpio_o=0, gpio_e=0, state IDLE, cnt=0, sts_udr=0, TREADY=0. TREADY goes high the first cycle after rstn deasserts.
// - Handshake: a sample is taken when TVALID&TREADY. TREADY=1 in IDLE/RUN and when cfg_ena=0; TREADY=0 in DEAD.
// - Latency: pins update on the clock edge after the accepting edge (1 register stage). No combinational path sti->gpio.
// - On accepting sample s: drv = ~gpio_e & s.e (bits newly driven).
//   - drv==0 or cfg_dtm==0: gpio_o<=s.o; gpio_e<=s.e. Next state RUN, or IDLE if TLAST.
//   - else: gpio_e<=gpio_e & s.e (releases apply now); gpio_o<=s.o; cnt<=cfg_dtm; store s and TLAST; go DEAD.
// - DEAD: cnt decrements each cycle. When cnt==1: gpio_e<=stored s.e; state RUN, or IDLE if stored TLAST.
//   - New drives therefore appear exactly cfg_dtm cycles after the release edge.
//   - cfg_dtm changes in DEAD have no effect until the next entry.
// - Underrun: state RUN and TVALID=0 -> sts_udr++ (saturate at all-ones).
//   - cfg_hld=0 also sets gpio_e<=0 (release needs no dead time); gpio_o is held.
//   - No underrun is counted in IDLE or DEAD.
// - TLAST: the sample is applied normally, then IDLE. IDLE holds the pins and does not count underruns.
// - cfg_ena=0 (any state, dominates):
//   - next edge gpio_e<=0; state IDLE; cnt<=0; stored sample dropped.
//   - Accepted samples are discarded.
// - sts_clr together with an increment: clear wins, sts_udr=0.
// - Width rules: cnt is CWD bits unsigned; sts_udr is CWU bits, saturating, never wraps.
// - States: IDLE (no active stream) -> RUN (sample applied) -> DEAD (waiting to drive) -> RUN/IDLE.
// STRUCTURE
// - lg_pkg: typedef struct packed {logic [DW-1:0] o; logic [DW-1:0] e;} lg_t; enum {IDLE,RUN,DEAD} lg_drv_st_t.
//   lg_t is shared with the generator's output stage.
// - Single module, no sub-modules. The dead-time counter and saturating counter are inline.
// TESTING
// - Reset with rstn low mid-DEAD -> gpio_e=0 and gpio_o=0 asynchronously; TREADY=1 one cycle after release; sts_act=0.
// - cfg_dtm=0, samples {o=A5,e=FF},{o=5A,e=0F} back-to-back
//   -> pins follow 1 cycle after each handshake; TREADY stays 1.
// - cfg_dtm=3: gpio_e=0F, then sample {o=F0,e=F0}
//   -> next edge gpio_e=00, gpio_o=F0; 3 cycles later gpio_e=F0.
//   -> TREADY low for exactly 3 cycles.
// - cfg_hld=0 in RUN, TVALID low 5 cycles -> gpio_e=00 from the first gap cycle; sts_udr=5.
//   - Repeat with cfg_hld=1 -> pins hold, sts_udr=10.
// - Sample with TLAST, then TVALID low 10 cycles -> state IDLE, sts_udr unchanged, pins hold last sample.
// - sts_udr at all-ones plus underrun -> stays all-ones.
//   - sts_clr coincident with underrun -> 0.
//   - cfg_ena=0 mid-DEAD -> gpio_e=00 next edge; stored drive never applied.

Source files
------------

// File: rtl/lg_pkg.sv
// Shared types for the logic-generator pin path: the {o,e} sample and the driver state.
package lg_pkg;

    localparam int unsigned LG_DW = 8;

    typedef struct packed {
        logic [LG_DW-1:0] o;
        logic [LG_DW-1:0] e;
    } lg_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DEAD = 2'd2
    } lg_drv_st_t;

endpackage

// File: rtl/axi4_stream_if.sv
// Minimal AXI4-stream bundle: DN lanes of payload type DT with valid/ready/last.
interface axi4_stream_if #(
    parameter int unsigned DN = 1,
    parameter type         DT = logic
);
    logic          tvalid;
    logic          tready;
    logic          tlast;
    DT [DN-1:0]    tdata;

    modport mst (output tvalid, output tdata, output tlast, input tready);
    modport slv (input tvalid, input tdata, input tlast, output tready);
endinterface

// File: rtl/lg_drv.sv
// GPIO pin driver fed by the logic-generator stream: break-before-make dead time on
// newly driven bits, hold/park on underrun, saturating underrun counter.
module lg_drv
    import lg_pkg::*;
#(
    parameter int unsigned DW  = LG_DW,
    parameter int unsigned CWD = 8,
    parameter int unsigned CWU = 16
) (
    input  logic           clk,
    input  logic           rstn,
    axi4_stream_if.slv     sti,
    input  logic           cfg_ena,
    input  logic           cfg_hld,
    input  logic [CWD-1:0] cfg_dtm,
    input  logic           sts_clr,
    output logic [DW-1:0]  gpio_o,
    output logic [DW-1:0]  gpio_e,
    output logic           sts_act,
    output logic [CWU-1:0] sts_udr
);

    lg_drv_st_t     st, st_n;
    logic [CWD-1:0] cnt, cnt_n;
    logic [DW-1:0]  o_n, e_n;
    logic [DW-1:0]  se, se_n;
    logic           sl, sl_n;
    logic [CWU-1:0] udr_n;
    logic           act_n;
    logic           rdy_q;
    logic           rdy;
    logic           acc;
    logic           udr_inc;
    logic [DW-1:0]  drv;
    lg_t            smp;

    // Ready only once out of reset; stalls while waiting out dead time unless disabled.
    assign rdy        = rdy_q & ((st != DEAD) | ~cfg_ena);
    assign sti.tready = rdy;
    assign acc        = sti.tvalid & rdy;
    assign smp        = sti.tdata[0];
    assign drv        = ~gpio_e & smp.e;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            st      <= IDLE;
            cnt     <= '0;
            gpio_o  <= '0;
            gpio_e  <= '0;
            se      <= '0;
            sl      <= 1'b0;
            sts_udr <= '0;
            sts_act <= 1'b0;
            rdy_q   <= 1'b0;
        end else begin
            st      <= st_n;
            cnt     <= cnt_n;
            gpio_o  <= o_n;
            gpio_e  <= e_n;
            se      <= se_n;
            sl      <= sl_n;
            sts_udr <= udr_n;
            sts_act <= act_n;
            rdy_q   <= 1'b1;
        end
    end

    always_comb begin
        st_n    = st;
        cnt_n   = cnt;
        o_n     = gpio_o;
        e_n     = gpio_e;
        se_n    = se;
        sl_n    = sl;
        udr_inc = 1'b0;

        if (!cfg_ena) begin
            // Disable releases every pin and forgets any pending drive.
            e_n   = '0;
            st_n  = IDLE;
            cnt_n = '0;
            se_n  = '0;
            sl_n  = 1'b0;
        end else begin
            unique case (st)
                IDLE, RUN: begin
                    if (acc) begin
                        o_n = smp.o;
                        if ((drv == '0) || (cfg_dtm == '0)) begin
                            e_n  = smp.e;
                            st_n = sti.tlast ? IDLE : RUN;
                        end else begin
                            // Releases happen now; new drives wait for the dead time.
                            e_n   = gpio_e & smp.e;
                            cnt_n = cfg_dtm;
                            se_n  = smp.e;
                            sl_n  = sti.tlast;
                            st_n  = DEAD;
                        end
                    end else if ((st == RUN) && !sti.tvalid) begin
                        udr_inc = 1'b1;
                        if (!cfg_hld) begin
                            e_n = '0;
                        end
                    end
                end
                DEAD: begin
                    cnt_n = cnt - CWD'(1);
                    if (cnt == CWD'(1)) begin
                        e_n  = se;
                        st_n = sl ? IDLE : RUN;
                    end
                end
                default: st_n = IDLE;
            endcase
        end

        if (sts_clr) begin
            udr_n = '0;
        end else if (udr_inc && (sts_udr != '1)) begin
            udr_n = sts_udr + CWU'(1);
        end else begin
            udr_n = sts_udr;
        end

        act_n = (st_n != IDLE);
    end

endmodule

// File: tb/tb_lg_drv.sv
// Directed bench for lg_drv: vector table for the streaming cases plus hand sequences
// for reset-in-dead-time and counter saturation.
module tb_lg_drv;
    import lg_pkg::*;

    localparam int unsigned UW = 6;

    typedef struct {
        logic           vld;
        logic [7:0]     o;
        logic [7:0]     e;
        logic           last;
        logic           ena;
        logic           hld;
        logic [7:0]     dtm;
        logic           clr;
        logic [7:0]     xo;
        logic [7:0]     xe;
        logic           xr;
        logic           xa;
        logic [UW-1:0]  xu;
    } vec_t;

    logic          clk;
    logic          rstn;
    logic          cfg_ena;
    logic          cfg_hld;
    logic [7:0]    cfg_dtm;
    logic          sts_clr;
    logic [7:0]    gpio_o;
    logic [7:0]    gpio_e;
    logic          sts_act;
    logic [UW-1:0] sts_udr;

    int n_run  = 0;
    int n_fail = 0;

    axi4_stream_if #(.DN(1), .DT(lg_t)) sti ();

    lg_drv #(.DW(8), .CWD(8), .CWU(UW)) dut (
        .clk     (clk),
        .rstn    (rstn),
        .sti     (sti),
        .cfg_ena (cfg_ena),
        .cfg_hld (cfg_hld),
        .cfg_dtm (cfg_dtm),
        .sts_clr (sts_clr),
        .gpio_o  (gpio_o),
        .gpio_e  (gpio_e),
        .sts_act (sts_act),
        .sts_udr (sts_udr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic vld, input logic [7:0] o, input logic [7:0] e,
                         input logic last);
        sti.tvalid     = vld;
        sti.tdata[0]   = lg_t'{o: o, e: e};
        sti.tlast      = last;
    endtask

    function automatic vec_t mk(input logic vld, input logic [7:0] o, input logic [7:0] e,
                                input logic last, input logic ena, input logic hld,
                                input logic [7:0] dtm, input logic clr,
                                input logic [7:0] xo, input logic [7:0] xe,
                                input logic xr, input logic xa, input logic [UW-1:0] xu);
        vec_t v;
        v.vld = vld; v.o = o; v.e = e; v.last = last; v.ena = ena; v.hld = hld;
        v.dtm = dtm; v.clr = clr; v.xo = xo; v.xe = xe; v.xr = xr; v.xa = xa; v.xu = xu;
        return v;
    endfunction

    vec_t tbl[$];

    initial begin
        // vld o e last ena hld dtm clr | gpio_o gpio_e tready act udr (after the edge)
        tbl.push_back(mk(1, 8'hA5, 8'hFF, 0, 1, 0, 8'd0, 0, 8'hA5, 8'hFF, 1, 1, 0));
        tbl.push_back(mk(1, 8'h5A, 8'h0F, 0, 1, 0, 8'd0, 0, 8'h5A, 8'h0F, 1, 1, 0));
        for (int i = 1; i <= 5; i++)
            tbl.push_back(mk(0, 8'h00, 8'h00, 0, 1, 0, 8'd0, 0, 8'h5A, 8'h00, 1, 1, UW'(i)));
        tbl.push_back(mk(1, 8'hA5, 8'hFF, 0, 1, 1, 8'd0, 0, 8'hA5, 8'hFF, 1, 1, 5));
        for (int i = 6; i <= 10; i++)
            tbl.push_back(mk(0, 8'h00, 8'h00, 0, 1, 1, 8'd0, 0, 8'hA5, 8'hFF, 1, 1, UW'(i)));
        tbl.push_back(mk(1, 8'h00, 8'h0F, 0, 1, 1, 8'd0, 0, 8'h00, 8'h0F, 1, 1, 10));
        // dead time of 3: release now, drive 3 edges later, ready low 3 cycles
        tbl.push_back(mk(1, 8'hF0, 8'hF0, 0, 1, 1, 8'd3, 0, 8'hF0, 8'h00, 0, 1, 10));
        tbl.push_back(mk(1, 8'h11, 8'hFF, 0, 1, 1, 8'd1, 0, 8'hF0, 8'h00, 0, 1, 10));
        tbl.push_back(mk(1, 8'h11, 8'hFF, 0, 1, 1, 8'd1, 0, 8'hF0, 8'h00, 0, 1, 10));
        tbl.push_back(mk(1, 8'h11, 8'hFF, 0, 1, 1, 8'd1, 0, 8'hF0, 8'hF0, 1, 1, 10));
        tbl.push_back(mk(1, 8'h11, 8'hFF, 0, 1, 1, 8'd1, 0, 8'h11, 8'hF0, 0, 1, 10));
        tbl.push_back(mk(0, 8'h00, 8'h00, 0, 1, 1, 8'd1, 0, 8'h11, 8'hFF, 1, 1, 10));
        // TLAST then idle gap: pins hold, no underrun counted
        tbl.push_back(mk(1, 8'h3C, 8'hFF, 1, 1, 1, 8'd1, 0, 8'h3C, 8'hFF, 1, 0, 10));
        for (int i = 0; i < 10; i++)
            tbl.push_back(mk(0, 8'h00, 8'h00, 0, 1, 1, 8'd1, 0, 8'h3C, 8'hFF, 1, 0, 10));
        // disable mid-dead-time: pending drive is never applied
        tbl.push_back(mk(1, 8'h00, 8'h0F, 0, 1, 1, 8'd0, 0, 8'h00, 8'h0F, 1, 1, 10));
        tbl.push_back(mk(1, 8'hF0, 8'hF0, 0, 1, 1, 8'd2, 0, 8'hF0, 8'h00, 0, 1, 10));
        tbl.push_back(mk(0, 8'h00, 8'h00, 0, 0, 1, 8'd2, 0, 8'hF0, 8'h00, 1, 0, 10));
        tbl.push_back(mk(0, 8'h00, 8'h00, 0, 1, 1, 8'd2, 0, 8'hF0, 8'h00, 1, 0, 10));
        tbl.push_back(mk(0, 8'h00, 8'h00, 0, 1, 1, 8'd2, 0, 8'hF0, 8'h00, 1, 0, 10));
        tbl.push_back(mk(1, 8'hAA, 8'hFF, 0, 0, 1, 8'd0, 0, 8'hF0, 8'h00, 1, 0, 10));
        tbl.push_back(mk(0, 8'h00, 8'h00, 0, 1, 1, 8'd0, 1, 8'hF0, 8'h00, 1, 0, 0));

        rstn = 1'b0;
        cfg_ena = 1'b1; cfg_hld = 1'b0; cfg_dtm = 8'd0; sts_clr = 1'b0;
        drive(0, 8'h00, 8'h00, 0);

        #12;
        chk("rst_gpio_o", 32'(gpio_o), 32'h0);
        chk("rst_gpio_e", 32'(gpio_e), 32'h0);
        chk("rst_tready", 32'(sti.tready), 32'h0);
        chk("rst_act", 32'(sts_act), 32'h0);
        @(negedge clk);
        rstn = 1'b1;
        #1;
        chk("rel_tready_low", 32'(sti.tready), 32'h0);
        tick();
        chk("rel_tready_high", 32'(sti.tready), 32'h1);

        foreach (tbl[i]) begin
            drive(tbl[i].vld, tbl[i].o, tbl[i].e, tbl[i].last);
            cfg_ena = tbl[i].ena;
            cfg_hld = tbl[i].hld;
            cfg_dtm = tbl[i].dtm;
            sts_clr = tbl[i].clr;
            tick();
            chk($sformatf("v%0d_gpio_o", i), 32'(gpio_o), 32'(tbl[i].xo));
            chk($sformatf("v%0d_gpio_e", i), 32'(gpio_e), 32'(tbl[i].xe));
            chk($sformatf("v%0d_tready", i), 32'(sti.tready), 32'(tbl[i].xr));
            chk($sformatf("v%0d_act", i), 32'(sts_act), 32'(tbl[i].xa));
            chk($sformatf("v%0d_udr", i), 32'(sts_udr), 32'(tbl[i].xu));
        end
        sts_clr = 1'b0;
        cfg_ena = 1'b1;

        // Saturation, then clear coincident with an underrun.
        cfg_hld = 1'b1; cfg_dtm = 8'd0;
        drive(1, 8'h12, 8'h34, 0);
        tick();
        chk("sat_start_e", 32'(gpio_e), 32'h34);
        drive(0, 8'h00, 8'h00, 0);
        repeat ((1 << UW) + 2) tick();
        chk("sat_udr", 32'(sts_udr), 32'((1 << UW) - 1));
        chk("sat_hold_o", 32'(gpio_o), 32'h12);
        sts_clr = 1'b1;
        tick();
        chk("clr_wins", 32'(sts_udr), 32'h0);
        sts_clr = 1'b0;
        tick();
        chk("udr_after_clr", 32'(sts_udr), 32'h1);

        // Asynchronous reset in the middle of dead time.
        cfg_dtm = 8'd3;
        drive(1, 8'h0F, 8'h0F, 0);
        tick();
        drive(1, 8'hF0, 8'hF0, 0);
        tick();
        chk("dead_entry_tready", 32'(sti.tready), 32'h0);
        drive(0, 8'h00, 8'h00, 0);
        #2;
        rstn = 1'b0;
        #1;
        chk("arst_gpio_o", 32'(gpio_o), 32'h0);
        chk("arst_gpio_e", 32'(gpio_e), 32'h0);
        chk("arst_act", 32'(sts_act), 32'h0);
        chk("arst_udr", 32'(sts_udr), 32'h0);
        @(negedge clk);
        rstn = 1'b1;
        tick();
        chk("arst_tready", 32'(sti.tready), 32'h1);
        chk("arst_act_after", 32'(sts_act), 32'h0);
        tick();
        chk("arst_no_drive", 32'(gpio_e), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
